// File: rtl/uart_txq_if.sv
// uart_txq_if: byte link between the transmit queue and the UART transmitter.
// The queue side (master) drives the byte and its write strobe.
// The transmitter side (slave) reports when it can take another byte.
`timescale 1ns/1ps
interface uart_txq_if;
   logic [7:0] tx_data;
   logic       tx_we;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_we,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_we,
      output tx_ready
   );
endinterface

// File: rtl/uart_txq.sv
// uart_txq: byte queue between the to_host MMIO write and the UART transmitter.
// Host writes are pushed into a circular buffer. A small drain FSM hands the
// bytes one at a time to the transmitter, keeping a guard window after every
// strobe so that the transmitter's READY is not sampled before it has dropped.
`timescale 1ns/1ps
module uart_txq #(
   parameter int DEPTH_LOG = 4,
   parameter int GUARD     = 2
) (
   input  logic                 clk,
   input  logic                 rst_async,
   input  logic [7:0]           wdata,
   input  logic                 we,
   output logic                 avail,
   output logic                 empty,
   output logic [DEPTH_LOG:0]   count,
   output logic                 ovf,
   input  logic                 ovf_clr,
   uart_txq_if.master           tx
);

   localparam int DEPTH  = 1 << DEPTH_LOG;
   localparam int PTR_W  = DEPTH_LOG + 1;
   localparam int GCNT_W = (GUARD < 2) ? 1 : $clog2(GUARD);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_GUARD,
      ST_WAIT
   } state_t;

   // Byte storage; no reset so it maps onto block RAM.
   logic [7:0]        mem [DEPTH];

   // Pointers carry one extra bit so that full and empty can be told apart.
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  wr_ptr_next;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_next;
   logic              ovf_reg;
   logic              ovf_next;

   state_t            state_reg;
   logic [GCNT_W-1:0] guard_cnt_reg;
   logic              tx_we_reg;
   logic [7:0]        tx_data_reg;

   logic [PTR_W-1:0]  occupancy;
   logic              full;
   logic              is_empty;
   logic              push;
   logic              pop;
   logic              ovf_set;

   // Occupancy flags and the push/pop decisions, all from registered state.
   always_comb begin
      occupancy = wr_ptr_reg - rd_ptr_reg;
      is_empty  = (wr_ptr_reg == rd_ptr_reg);
      full      = (occupancy == PTR_W'(DEPTH));
      // Fullness is taken at the start of the cycle, so a pop in the same
      // cycle does not make room for a push into a full queue.
      push      = we && !full;
      ovf_set   = we && full;
      // The head leaves the queue on the edge that starts the strobe.
      pop       = (state_reg == ST_IDLE) && !is_empty && tx.tx_ready;
   end

   // Next-state for the pointers and the sticky overflow flag (set wins).
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      ovf_next    = ovf_reg;
      if (push) begin
         wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      if (ovf_set) begin
         ovf_next = 1'b1;
      end else if (ovf_clr) begin
         ovf_next = 1'b0;
      end
   end

   // Write port of the byte storage.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg[DEPTH_LOG-1:0]] <= wdata;
      end
   end

   // Pointer and overflow registers; a reset discards everything queued.
   // While reset is low every edge is ignored, including one that lines up
   // with the release, so a write on that edge is lost by construction.
   always_ff @(posedge clk or negedge rst_async) begin
      if (!rst_async) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         ovf_reg    <= 1'b0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         ovf_reg    <= ovf_next;
      end
   end

   // Drain FSM with registered strobe and data: IDLE -> ISSUE -> GUARD -> WAIT.
   always_ff @(posedge clk or negedge rst_async) begin
      if (!rst_async) begin
         state_reg     <= ST_IDLE;
         guard_cnt_reg <= '0;
         tx_we_reg     <= 1'b0;
         tx_data_reg   <= 8'h00;
      end else begin
         tx_we_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (pop) begin
                  tx_we_reg   <= 1'b1;
                  tx_data_reg <= mem[rd_ptr_reg[DEPTH_LOG-1:0]];
                  state_reg   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (GUARD == 0) begin
                  state_reg <= ST_WAIT;
               end else begin
                  guard_cnt_reg <= GCNT_W'(GUARD - 1);
                  state_reg     <= ST_GUARD;
               end
            end
            ST_GUARD: begin
               // READY is still high from before the strobe; do not look at it.
               if (guard_cnt_reg == '0) begin
                  state_reg <= ST_WAIT;
               end else begin
                  guard_cnt_reg <= guard_cnt_reg - GCNT_W'(1);
               end
            end
            ST_WAIT: begin
               if (tx.tx_ready) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign avail      = !full;
   assign empty      = is_empty;
   assign count      = occupancy;
   assign ovf        = ovf_reg;
   assign tx.tx_we   = tx_we_reg;
   assign tx.tx_data = tx_data_reg;

endmodule

// File: tb/tb_uart_txq.sv
// tb_uart_txq: randomized self-checking bench for uart_txq.
// A queue-level reference model tracks accepted bytes, occupancy and the
// overflow flag; each scenario task compares the DUT against it inline.
`timescale 1ns/1ps
module tb_uart_txq;
   localparam int DEPTH_LOG = 4;
   localparam int DEPTH     = 1 << DEPTH_LOG;
   localparam int GUARD     = 2;

   logic                 clk = 1'b0;
   logic                 rst_async;
   logic [7:0]           wdata;
   logic                 we;
   logic                 avail;
   logic                 empty;
   logic [DEPTH_LOG:0]   count;
   logic                 ovf;
   logic                 ovf_clr;
   logic                 tx_ready;

   uart_txq_if tx_link ();
   assign tx_link.tx_ready = tx_ready;

   uart_txq #(.DEPTH_LOG(DEPTH_LOG), .GUARD(GUARD)) dut (
      .clk       (clk),
      .rst_async (rst_async),
      .wdata     (wdata),
      .we        (we),
      .avail     (avail),
      .empty     (empty),
      .count     (count),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr),
      .tx        (tx_link)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model state
   int         mcount;
   bit         exp_ovf;
   logic [7:0] acc_q[$];
   logic [7:0] rx_q[$];
   int         cyc;
   int         last_we_cyc;
   int         we_nr_viol;
   int         gap_viol;
   int         pop_empty_viol;
   int         x_viol;

   // Transmitter model: READY falls one cycle after a strobe, for busy_len cycles
   bit uart_en;
   int busy_len;
   bit pend;
   int busy;

   task automatic model_reset();
      mcount      = 0;
      exp_ovf     = 1'b0;
      acc_q.delete();
      rx_q.delete();
      last_we_cyc = -1;
   endtask

   // One clock: inputs are held across the edge, outputs observed at the falling edge.
   task automatic tick();
      logic       we_s;
      logic       clr_s;
      logic [7:0] wd_s;
      int         sz0;
      bit         seen_we;
      we_s  = we;
      clr_s = ovf_clr;
      wd_s  = wdata;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (!rst_async) begin
         model_reset();
      end else begin
         sz0     = mcount;
         seen_we = (tx_link.tx_we === 1'b1);
         if ($isunknown(tx_link.tx_we)) x_viol++;
         if (seen_we) begin
            if (!tx_ready) we_nr_viol++;
            if (last_we_cyc >= 0 && (cyc - last_we_cyc) < GUARD + 2) gap_viol++;
            last_we_cyc = cyc;
            rx_q.push_back(tx_link.tx_data);
            if (sz0 == 0) pop_empty_viol++;
            else mcount--;
         end
         if (we_s && sz0 < DEPTH) begin
            acc_q.push_back(wd_s);
            mcount++;
         end
         if (we_s && sz0 >= DEPTH) exp_ovf = 1'b1;
         else if (clr_s) exp_ovf = 1'b0;
         if (uart_en) begin
            if (pend) begin
               tx_ready = 1'b0;
               busy     = busy_len;
               pend     = 1'b0;
            end else if (busy > 0) begin
               busy--;
               if (busy == 0) tx_ready = 1'b1;
            end
            if (seen_we) pend = 1'b1;
         end
      end
   endtask

   task automatic drain(input int max_cycles);
      int n;
      n = 0;
      while (rx_q.size() < acc_q.size() && n < max_cycles) begin
         tick();
         n++;
      end
      repeat (GUARD + 6) tick();
   endtask

   task automatic test_reset();
      rst_async = 1'b0;
      we = 1'b0; wdata = 8'h00; ovf_clr = 1'b0; tx_ready = 1'b1;
      uart_en = 1'b0; pend = 1'b0; busy = 0; busy_len = 1;
      cyc = 0; we_nr_viol = 0; gap_viol = 0; pop_empty_viol = 0; x_viol = 0;
      model_reset();
      repeat (3) @(negedge clk);
      tests_run++; if (count !== 5'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", count); end
      tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b want 1", empty); end
      tests_run++; if (avail !== 1'b1) begin tests_failed++; $display("FAIL reset_avail: got %b want 1", avail); end
      tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b want 0", ovf); end
      tests_run++; if (tx_link.tx_we !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_we: got %b want 0", tx_link.tx_we); end
      tests_run++; if (tx_link.tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data: got %h want 00", tx_link.tx_data); end
      rst_async = 1'b1;
      repeat (3) tick();
      tests_run++; if (tx_link.tx_we !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_we: got %b want 0", tx_link.tx_we); end
      $display("[TB] reset: done");
   endtask

   task automatic test_single();
      tx_ready = 1'b1;
      wdata = 8'h41; we = 1'b1;
      tick();
      we = 1'b0;
      tests_run++; if (count !== 5'd1) begin tests_failed++; $display("FAIL single_count_push: got %0d want 1", count); end
      tests_run++; if (tx_link.tx_we !== 1'b0) begin tests_failed++; $display("FAIL single_we_early: got %b want 0", tx_link.tx_we); end
      tick();
      tests_run++; if (tx_link.tx_we !== 1'b1) begin tests_failed++; $display("FAIL single_we: got %b want 1", tx_link.tx_we); end
      tests_run++; if (tx_link.tx_data !== 8'h41) begin tests_failed++; $display("FAIL single_data: got %h want 41", tx_link.tx_data); end
      tests_run++; if (count !== 5'd0) begin tests_failed++; $display("FAIL single_count_pop: got %0d want 0", count); end
      tick();
      tests_run++; if (tx_link.tx_we !== 1'b0) begin tests_failed++; $display("FAIL single_we_width: got %b want 0", tx_link.tx_we); end
      tests_run++; if (tx_link.tx_data !== 8'h41) begin tests_failed++; $display("FAIL single_data_hold: got %h want 41", tx_link.tx_data); end
      drain(50);
      model_reset();
      $display("[TB] single push 41: done");
   endtask

   task automatic test_fill_ovf();
      tx_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         wdata = 8'(i); we = 1'b1;
         tick();
      end
      tests_run++; if (avail !== 1'b0) begin tests_failed++; $display("FAIL fill_avail: got %b want 0", avail); end
      tests_run++; if (count !== 5'd16) begin tests_failed++; $display("FAIL fill_count: got %0d want 16", count); end
      tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL fill_ovf_early: got %b want 0", ovf); end
      wdata = 8'hAA;
      tick();
      we = 1'b0;
      tests_run++; if (ovf !== 1'b1) begin tests_failed++; $display("FAIL fill_ovf: got %b want 1", ovf); end
      tests_run++; if (count !== 5'd16) begin tests_failed++; $display("FAIL fill_count_ovf: got %0d want 16", count); end
      tick();
      tests_run++; if (rx_q.size() !== 0) begin tests_failed++; $display("FAIL fill_no_issue: got %0d strobes want 0", rx_q.size()); end
      tx_ready = 1'b1;
      drain(400);
      tests_run++; if (rx_q.size() !== DEPTH) begin tests_failed++; $display("FAIL fill_rx_len: got %0d want %0d", rx_q.size(), DEPTH); end
      for (int i = 0; i < DEPTH && i < rx_q.size(); i++) begin
         tests_run++; if (rx_q[i] !== 8'(i)) begin tests_failed++; $display("FAIL fill_rx[%0d]: got %h want %h", i, rx_q[i], 8'(i)); end
      end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL fill_ovf_clr: got %b want 0", ovf); end
      model_reset();
      $display("[TB] fill 0x00..0x0F and overflow: done");
   endtask

   task automatic test_full_push_pop();
      logic [7:0] exp_b[$];
      tx_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         wdata = 8'($urandom); we = 1'b1;
         exp_b.push_back(wdata);
         tick();
      end
      tx_ready = 1'b1;
      wdata = 8'h77; we = 1'b1;
      tick();
      we = 1'b0;
      tests_run++; if (count !== 5'd15) begin tests_failed++; $display("FAIL fpp_count: got %0d want 15", count); end
      tests_run++; if (ovf !== 1'b1) begin tests_failed++; $display("FAIL fpp_ovf: got %b want 1", ovf); end
      tests_run++; if (tx_link.tx_we !== 1'b1) begin tests_failed++; $display("FAIL fpp_we: got %b want 1", tx_link.tx_we); end
      tests_run++; if (tx_link.tx_data !== exp_b[0]) begin tests_failed++; $display("FAIL fpp_data: got %h want %h", tx_link.tx_data, exp_b[0]); end
      drain(400);
      tests_run++; if (rx_q.size() !== exp_b.size()) begin tests_failed++; $display("FAIL fpp_rx_len: got %0d want %0d", rx_q.size(), exp_b.size()); end
      for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++) begin
         tests_run++; if (rx_q[i] !== exp_b[i]) begin tests_failed++; $display("FAIL fpp_rx[%0d]: got %h want %h", i, rx_q[i], exp_b[i]); end
      end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      model_reset();
      $display("[TB] full queue push+pop: done");
   endtask

   task automatic test_ovf_clr();
      logic [7:0] exp_b[$];
      tx_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         wdata = 8'($urandom); we = 1'b1;
         exp_b.push_back(wdata);
         tick();
      end
      wdata = 8'($urandom); ovf_clr = 1'b1;
      tick();
      we = 1'b0; ovf_clr = 1'b0;
      tests_run++; if (ovf !== 1'b1) begin tests_failed++; $display("FAIL ovfclr_set_wins: got %b want 1", ovf); end
      tick();
      tests_run++; if (ovf !== 1'b1) begin tests_failed++; $display("FAIL ovfclr_sticky: got %b want 1", ovf); end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL ovfclr_clear: got %b want 0", ovf); end
      tx_ready = 1'b1;
      drain(400);
      tests_run++; if (rx_q.size() !== exp_b.size()) begin tests_failed++; $display("FAIL ovfclr_rx_len: got %0d want %0d", rx_q.size(), exp_b.size()); end
      for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++) begin
         tests_run++; if (rx_q[i] !== exp_b[i]) begin tests_failed++; $display("FAIL ovfclr_rx[%0d]: got %h want %h", i, rx_q[i], exp_b[i]); end
      end
      model_reset();
      $display("[TB] overflow clear priority: done");
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_b[$];
      int         n;
      int         av_bad;
      uart_en = 1'b1; busy_len = 120; pend = 1'b0; busy = 0; tx_ready = 1'b1;
      we_nr_viol = 0; gap_viol = 0; pop_empty_viol = 0; x_viol = 0;
      n = 0; av_bad = 0;
      while (exp_b.size() < 40 && n < 20000) begin
         if (avail !== (mcount < DEPTH)) av_bad++;
         if (mcount < DEPTH) begin
            wdata = 8'($urandom); we = 1'b1;
            exp_b.push_back(wdata);
         end else begin
            we = 1'b0;
         end
         tick();
         n++;
      end
      we = 1'b0;
      drain(40 * 130 + 200);
      uart_en = 1'b0; tx_ready = 1'b1;
      tests_run++; if (av_bad !== 0) begin tests_failed++; $display("FAIL b2b_avail: got %0d bad cycles want 0", av_bad); end
      tests_run++; if (rx_q.size() !== 40) begin tests_failed++; $display("FAIL b2b_rx_len: got %0d want 40", rx_q.size()); end
      for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++) begin
         tests_run++; if (rx_q[i] !== exp_b[i]) begin tests_failed++; $display("FAIL b2b_rx[%0d]: got %h want %h", i, rx_q[i], exp_b[i]); end
      end
      tests_run++; if (we_nr_viol !== 0) begin tests_failed++; $display("FAIL b2b_we_not_ready: got %0d want 0", we_nr_viol); end
      tests_run++; if (gap_viol !== 0) begin tests_failed++; $display("FAIL b2b_gap: got %0d short gaps want 0", gap_viol); end
      tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL b2b_ovf: got %b want 0", ovf); end
      repeat (4) tick();
      model_reset();
      $display("[TB] back-to-back 40 bytes, slow transmitter: done");
   endtask

   task automatic test_random();
      int bad_cnt, bad_ovf, bad_av, bad_em;
      uart_en = 1'b1; busy_len = 3; pend = 1'b0; busy = 0; tx_ready = 1'b1;
      we_nr_viol = 0; gap_viol = 0; pop_empty_viol = 0; x_viol = 0;
      bad_cnt = 0; bad_ovf = 0; bad_av = 0; bad_em = 0;
      for (int n = 0; n < 400; n++) begin
         we      = 1'($urandom_range(0, 1));
         wdata   = 8'($urandom);
         ovf_clr = ($urandom_range(0, 9) == 0);
         tick();
         if (count !== 5'(mcount)) bad_cnt++;
         if (ovf !== exp_ovf) bad_ovf++;
         if (avail !== (mcount < DEPTH)) bad_av++;
         if (empty !== (mcount == 0)) bad_em++;
      end
      we = 1'b0; ovf_clr = 1'b0;
      drain(400);
      tests_run++; if (bad_cnt !== 0) begin tests_failed++; $display("FAIL rnd_count: got %0d bad cycles want 0", bad_cnt); end
      tests_run++; if (bad_ovf !== 0) begin tests_failed++; $display("FAIL rnd_ovf: got %0d bad cycles want 0", bad_ovf); end
      tests_run++; if (bad_av !== 0) begin tests_failed++; $display("FAIL rnd_avail: got %0d bad cycles want 0", bad_av); end
      tests_run++; if (bad_em !== 0) begin tests_failed++; $display("FAIL rnd_empty: got %0d bad cycles want 0", bad_em); end
      tests_run++; if (rx_q.size() !== acc_q.size()) begin tests_failed++; $display("FAIL rnd_rx_len: got %0d want %0d", rx_q.size(), acc_q.size()); end
      for (int i = 0; i < acc_q.size() && i < rx_q.size(); i++) begin
         tests_run++; if (rx_q[i] !== acc_q[i]) begin tests_failed++; $display("FAIL rnd_rx[%0d]: got %h want %h", i, rx_q[i], acc_q[i]); end
      end
      tests_run++; if (we_nr_viol + gap_viol + pop_empty_viol + x_viol !== 0) begin
         tests_failed++;
         $display("FAIL rnd_protocol: got notready=%0d gap=%0d popempty=%0d x=%0d want all 0", we_nr_viol, gap_viol, pop_empty_viol, x_viol);
      end
      uart_en = 1'b0; tx_ready = 1'b1;
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      repeat (4) tick();
      model_reset();
      $display("[TB] random traffic: done");
   endtask

   task automatic test_reset_mid();
      bit seen;
      tx_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         wdata = 8'($urandom); we = 1'b1;
         tick();
      end
      we = 1'b0;
      tx_ready = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         tick();
         if (tx_link.tx_we === 1'b1) seen = 1'b1;
      end
      tests_run++; if (!seen) begin tests_failed++; $display("FAIL rstmid_first_we: got none want strobe within 20 cycles"); end
      tick();
      tests_run++; if (count !== 5'd5) begin tests_failed++; $display("FAIL rstmid_count_before: got %0d want 5", count); end
      rst_async = 1'b0;
      #1;
      tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL rstmid_empty: got %b want 1", empty); end
      tests_run++; if (count !== 5'd0) begin tests_failed++; $display("FAIL rstmid_count: got %0d want 0", count); end
      tests_run++; if (tx_link.tx_we !== 1'b0) begin tests_failed++; $display("FAIL rstmid_we: got %b want 0", tx_link.tx_we); end
      tests_run++; if (tx_link.tx_data !== 8'h00) begin tests_failed++; $display("FAIL rstmid_data: got %h want 00", tx_link.tx_data); end
      @(negedge clk);
      repeat (2) tick();
      rst_async = 1'b1;
      repeat (30) tick();
      tests_run++; if (rx_q.size() !== 0) begin tests_failed++; $display("FAIL rstmid_no_we: got %0d strobes want 0", rx_q.size()); end
      tests_run++; if (count !== 5'd0) begin tests_failed++; $display("FAIL rstmid_count_after: got %0d want 0", count); end
      wdata = 8'h5A; we = 1'b1;
      tick();
      we = 1'b0;
      drain(50);
      tests_run++; if (rx_q.size() !== 1) begin tests_failed++; $display("FAIL rstmid_new_len: got %0d want 1", rx_q.size()); end
      if (rx_q.size() > 0) begin
         tests_run++; if (rx_q[0] !== 8'h5A) begin tests_failed++; $display("FAIL rstmid_new_data: got %h want 5a", rx_q[0]); end
      end
      model_reset();
      $display("[TB] reset during guard: done");
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_ovf();
      test_full_push_pop();
      test_ovf_clr();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, run %0d failed %0d", tests_run, tests_failed);
      $fatal(1, "watchdog");
   end

endmodule
